// File: rtl/apb_pkg.sv
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared APB types and constants for the master and slave blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  // Width of the slave wait-state counter (0..15 extra access cycles).
  localparam int WAIT_CNT_W = 4;

  // Master-side transfer sequencing.
  typedef enum logic [1:0] {
    MST_IDLE   = 2'd0,
    MST_SETUP  = 2'd1,
    MST_ACCESS = 2'd2
  } apb_mst_state_t;

  // Slave-side transfer sequencing.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_t;

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_mem_array.sv
// ============================================================================
// Module  : apb_mem_array
// Brief   : Word-addressed storage with synchronous write, asynchronous read
//           and synchronous clear of every word on reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear all words on reset, otherwise commit a single-word write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational; the caller masks out-of-range indices.
  assign rdata = mem[raddr];

endmodule : apb_mem_array

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module  : apb_slave_mem
// Brief   : APB slave fronting a word memory with a read-only upper region,
//           programmable wait states and error response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int RO_BASE     = 48,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Limits widened by one bit so large parameter values compare correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] RO_LIM    = (ADDR_WIDTH+1)'(RO_BASE);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  apb_slv_state_t        state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  err;

  logic                  setup;
  logic                  addr_err;
  logic                  mem_we;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign setup    = psel && !penable;
  assign addr_err = ({1'b0, paddr} >= DEPTH_LIM) ||
                    (pwrite && ({1'b0, paddr} >= RO_LIM));
  assign idx      = paddr[IDX_W-1:0];

  // Completion is gated by reset so an access aborted by reset never shows pready.
  assign pready  = preset_n && (state == ACCESS) && psel && penable && (cnt == '0);
  assign pslverr = pready && err;
  assign mem_we  = pready && pwrite && !err;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .rst_n (preset_n),
    .we    (mem_we),
    .waddr (idx),
    .wdata (pwdata),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  // Transfer FSM: latch error/read data at setup, count wait states, retire on pready.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      err    <= 1'b0;
      prdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state  <= ACCESS;
            cnt    <= WAIT_LOAD;
            err    <= addr_err;
            prdata <= (addr_err || pwrite) ? '0 : mem_rdata;
          end
        end
        ACCESS: begin
          if (!psel) begin
            // Master abandoned the transfer: drop it without writing.
            state  <= IDLE;
            cnt    <= '0;
            err    <= 1'b0;
            prdata <= '0;
          end else if (setup) begin
            // A fresh setup phase restarts the access immediately.
            state  <= ACCESS;
            cnt    <= WAIT_LOAD;
            err    <= addr_err;
            prdata <= (addr_err || pwrite) ? '0 : mem_rdata;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= IDLE;
            err    <= 1'b0;
            prdata <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          err    <= 1'b0;
          prdata <= '0;
        end
      endcase
    end
  end

endmodule : apb_slave_mem

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// Module  : tb_apb_slave_mem
// Brief   : Directed self-checking bench; one slave with two wait states and
//           one with none share a single APB bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [31:0] prdata, prdata0;
  logic        pready, pready0;
  logic        pslverr, pslverr0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_STATES(2)) dut (
    .pclk(clk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .pclk(clk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 just after the completing edge.
  task automatic xfer(input bit ws0, input bit wr, input logic [15:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int ncyc);
    bit done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    #3;
    chk("setup_pready", {31'b0, (ws0 ? pready0 : pready)}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    ncyc = 0; rd = '0; er = 1'b0; done = 1'b0;
    while (!done && ncyc < 20) begin
      ncyc++;
      #3;
      if (ws0 ? pready0 : pready) begin
        rd   = ws0 ? prdata0 : prdata;
        er   = ws0 ? pslverr0 : pslverr;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("xfer_done", {31'b0, done}, 32'd1);
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    preset_n = 1'b1;
    @(posedge clk); #1;

    // Read after reset: completes on third access cycle
    xfer(1'b0, 1'b0, 16'd5, 32'd0, rd, er, n);
    chk("rd5_cycles", n, 32'd3);
    chk("rd5_data", rd, 32'd0);
    chk("rd5_err", {31'b0, er}, 32'd0);
    bus_idle();

    // Write then read back
    xfer(1'b0, 1'b1, 16'd5, 32'hDEADBEEF, rd, er, n);
    chk("wr5_cycles", n, 32'd3);
    chk("wr5_err", {31'b0, er}, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd5, 32'd0, rd, er, n);
    chk("rd5b_data", rd, 32'hDEADBEEF);
    chk("rd5b_err", {31'b0, er}, 32'd0);
    bus_idle();
    #3;
    chk("idle_prdata_clear", prdata, 32'd0);
    chk("idle_pready", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;

    // Read-only region
    xfer(1'b0, 1'b1, 16'd50, 32'h1, rd, er, n);
    chk("wr50_err", {31'b0, er}, 32'd1);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd50, 32'd0, rd, er, n);
    chk("rd50_data", rd, 32'd0);
    chk("rd50_err", {31'b0, er}, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b1, 16'd47, 32'h4747, rd, er, n);
    chk("wr47_err", {31'b0, er}, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd47, 32'd0, rd, er, n);
    chk("rd47_data", rd, 32'h4747);
    bus_idle();
    xfer(1'b0, 1'b1, 16'd48, 32'h4848, rd, er, n);
    chk("wr48_err", {31'b0, er}, 32'd1);
    bus_idle();

    // Out of range
    xfer(1'b0, 1'b0, 16'd64, 32'd0, rd, er, n);
    chk("rd64_err", {31'b0, er}, 32'd1);
    chk("rd64_data", rd, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b1, 16'd64, 32'h64, rd, er, n);
    chk("wr64_err", {31'b0, er}, 32'd1);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd63, 32'd0, rd, er, n);
    chk("rd63_err", {31'b0, er}, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd5, 32'd0, rd, er, n);
    chk("rd5_unchanged", rd, 32'hDEADBEEF);
    bus_idle();

    // psel+penable seen in IDLE is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'd9; pwdata = 32'h99;
    #3;
    chk("idle_pen_pready", {31'b0, pready}, 32'd0);
    @(posedge clk); #4;
    chk("idle_pen_pready2", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;
    bus_idle();
    xfer(1'b0, 1'b0, 16'd9, 32'd0, rd, er, n);
    chk("rd9_data", rd, 32'd0);
    bus_idle();

    // psel dropped mid-access: no write, prdata cleared
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd8; pwdata = 32'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    xfer(1'b0, 1'b0, 16'd8, 32'd0, rd, er, n);
    chk("rd8_after_drop", rd, 32'd0);
    bus_idle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'd5;
    @(posedge clk); #4;
    chk("rd5_setup_latch", prdata, 32'hDEADBEEF);
    #1 penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #3;
    chk("drop_prdata_clear", prdata, 32'd0);
    @(posedge clk); #1;

    // Back-to-back on the zero-wait-state slave
    xfer(1'b1, 1'b1, 16'd3, 32'h12345678, rd, er, n);
    chk("b2b_wr_cycles", n, 32'd1);
    chk("b2b_wr_err", {31'b0, er}, 32'd0);
    xfer(1'b1, 1'b0, 16'd3, 32'd0, rd, er, n);
    chk("b2b_rd_cycles", n, 32'd1);
    chk("b2b_rd_data", rd, 32'h12345678);
    bus_idle();

    // Reset during second access cycle of write to 7 (two wait states)
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd7; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    preset_n = 1'b0;
    #3;
    chk("rst_mid_pready", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;
    preset_n = 1'b1;
    bus_idle();
    xfer(1'b0, 1'b0, 16'd7, 32'd0, rd, er, n);
    chk("rd7_after_rst", rd, 32'd0);
    bus_idle();
    xfer(1'b0, 1'b0, 16'd5, 32'd0, rd, er, n);
    chk("rd5_cleared_by_rst", rd, 32'd0);
    bus_idle();

    // Reset on the completing cycle of the zero-wait-state slave
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'd7; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    preset_n = 1'b0;
    #3;
    chk("rst_mid_pready0", {31'b0, pready0}, 32'd0);
    chk("rst_mid_pslverr0", {31'b0, pslverr0}, 32'd0);
    @(posedge clk); #1;
    preset_n = 1'b1;
    bus_idle();
    xfer(1'b1, 1'b0, 16'd7, 32'd0, rd, er, n);
    chk("rd7_ws0_after_rst", rd, 32'd0);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_apb_slave_mem

`default_nettype wire
